// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer in front of tt_um_viterbi_core.
// Forwards framed symbols to the core, injects TB_LAG zero flush symbols
// with force_state0 at frame end, strips the lag bits and emits one decoded
// bit per input symbol with a frame-last marker.
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_sym/in_last
// upstream; core_sym_valid/core_sym_ready/core_sym/core_force_state0 to the
// core; core_dec_valid/core_dec_bit from the core; out_valid/out_bit/out_last
// decoded stream; busy (not IDLE); len_err (sticky overlength flag).
module viterbi_frame_ctrl #(
  parameter int TB_LAG    = 23,
  parameter int MAX_FRAME = 1023,
  parameter int CW        = $clog2(MAX_FRAME + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
  input  logic       in_last,
  output logic       core_sym_valid,
  input  logic       core_sym_ready,
  output logic [1:0] core_sym,
  output logic       core_force_state0,
  input  logic       core_dec_valid,
  input  logic       core_dec_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic       len_err
);
  localparam int LW = $clog2(TB_LAG + 1);
  typedef enum logic [1:0] {IDLE, PASS, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] sym_cnt_q, sym_cnt_d, frame_len_q, frame_len_d, out_cnt_q, out_cnt_d;
  logic [LW-1:0] flush_cnt_q, flush_cnt_d, dec_cnt_q, dec_cnt_d;
  logic out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_last_q, out_last_d;
  logic len_err_q, len_err_d;
  logic accepting, in_hs, core_hs, sym_sat, done, lag, fwd;
  assign accepting         = (state_q == IDLE) || (state_q == PASS);
  assign in_ready          = accepting && core_sym_ready;
  assign core_sym_valid    = (state_q == FLUSH) || (accepting && in_valid);
  assign core_sym          = accepting ? in_sym : 2'b00;
  assign core_force_state0 = !accepting;
  assign busy              = state_q != IDLE;
  assign in_hs             = in_valid && in_ready;
  assign core_hs           = core_sym_valid && core_sym_ready;
  assign sym_sat           = sym_cnt_q == CW'(MAX_FRAME);
  assign done              = out_cnt_q == frame_len_q;
  assign lag               = dec_cnt_q < LW'(TB_LAG);
  // frame_len is only known once the frame has ended (FLUSH/DRAIN); until
  // then the output count is bounded by MAX_FRAME alone.
  assign fwd = core_dec_valid && !lag &&
               !(core_force_state0 ? done : out_cnt_q == CW'(MAX_FRAME));
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    frame_len_d = frame_len_q;
    flush_cnt_d = flush_cnt_q;
    len_err_d   = len_err_q;
    case (state_q)
      IDLE: if (in_hs) begin
        sym_cnt_d   = CW'(1);
        frame_len_d = CW'(1);
        flush_cnt_d = '0;
        state_d     = in_last ? FLUSH : PASS;
      end
      PASS: if (in_hs) begin
        sym_cnt_d = sym_sat ? sym_cnt_q : sym_cnt_q + CW'(1);
        len_err_d = len_err_q || sym_sat;
        if (in_last) begin
          frame_len_d = sym_cnt_d;
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end
      end
      FLUSH: if (core_hs) begin
        flush_cnt_d = flush_cnt_q + LW'(1);
        state_d     = (flush_cnt_q == LW'(TB_LAG - 1)) ? DRAIN : FLUSH;
      end
      default: state_d = done ? IDLE : DRAIN;
    endcase
  end
  always_comb begin
    dec_cnt_d   = (core_dec_valid && lag) ? dec_cnt_q + LW'(1) : dec_cnt_q;
    out_cnt_d   = fwd ? out_cnt_q + CW'(1) : out_cnt_q;
    out_valid_d = fwd;
    out_bit_d   = fwd && core_dec_bit;
    out_last_d  = fwd && core_force_state0 && (out_cnt_q + CW'(1) == frame_len_q);
    if ((state_q == IDLE && in_hs) || (state_q == DRAIN && done)) dec_cnt_d = '0;
    if (state_q == DRAIN && done) out_cnt_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      frame_len_q <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      dec_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      frame_len_q <= frame_len_d;
      out_cnt_q   <= out_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign len_err   = len_err_q;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: directed checks of viterbi_frame_ctrl against a lag-line core model.
module tb_viterbi_frame_ctrl;
  localparam int LAG = 23, MAXF = 1023;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, core_sym_ready = 1;
  logic [1:0] in_sym = 0;
  logic in_ready, core_sym_valid, core_force_state0, core_dec_valid, core_dec_bit;
  logic [1:0] core_sym;
  logic out_valid, out_bit, out_last, busy, len_err;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, rdy_mode = 0;
  int n_acc, n_facc, n_out, n_last, last_cyc, fall_cyc, first_wait;
  int bad_ready = 0, bad_force = 0, bad_last = 0;
  int last_at[0:7];
  bit obits[0:2047];
  logic [1:0] syms[0:2047];
  bit q[$];
  bit b;
  typedef struct {
    logic iv; logic [1:0] sym; logic rdy;
    logic e_ir; logic e_cv; logic [1:0] e_cs;
  } vec_t;
  vec_t vt[4];

  viterbi_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .in_last(in_last), .core_sym_valid(core_sym_valid), .core_sym_ready(core_sym_ready),
    .core_sym(core_sym), .core_force_state0(core_force_state0),
    .core_dec_valid(core_dec_valid), .core_dec_bit(core_dec_bit),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Core model: one decoded bit per accepted symbol, equal to the parity of
  // the symbol accepted LAG earlier (zero while the line is filling).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      core_dec_valid <= 0;
      core_dec_bit   <= 0;
    end else begin
      core_dec_valid <= core_sym_valid && core_sym_ready;
      if (core_sym_valid && core_sym_ready) begin
        q.push_back(^core_sym);
        b = (q.size() > LAG) ? q.pop_front() : 1'b0;
        core_dec_bit <= b;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    #1;
    if (rdy_mode == 0) core_sym_ready = 1;
    else if (rdy_mode == 1) core_sym_ready = (cyc % 4 == 0);
  end

  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (core_sym_valid && core_sym_ready) begin
        n_acc++;
        if (core_force_state0) n_facc++;
      end
      if (out_last && !out_valid) bad_last++;
      if (out_valid) begin
        if (n_out < 2048) obits[n_out] = out_bit;
        if (out_last) begin
          if (n_last < 8) last_at[n_last] = n_out;
          n_last++;
          last_cyc = cyc;
        end
        n_out++;
      end
      if (!busy && fall_cyc < 0 && n_last > 0) fall_cyc = cyc;
      if (core_force_state0 && in_ready) bad_ready++;
      if (!busy && core_force_state0) bad_force++;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_acc = 0; n_facc = 0; n_out = 0; n_last = 0; last_cyc = 0; fall_cyc = -1;
    for (int i = 0; i < 8; i++) last_at[i] = -1;
  endtask

  task automatic fill(int n, int seed);
    for (int i = 0; i < n; i++) syms[i] = 2'((i * 7 + i / 3 + seed) % 4);
  endtask

  task automatic send(int n, int off, bit drop);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      bit hs = 0;
      while (!hs) begin
        @(negedge clk);
        #2;
        in_valid = 1; in_sym = syms[off + i]; in_last = (i == n - 1);
        #1;
        hs = in_ready;
        g++;
        if (g > 5000) begin
          chk("handshake_timeout", 0, 1);
          return;
        end
      end
      if (i == 0) first_wait = g;
    end
    if (drop) begin
      @(negedge clk);
      #2;
      in_valid = 0; in_last = 0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      #4;
      g++;
    end while (busy && g < 5000);
    if (busy) chk("idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_out(string t, int n_exp, int exp_acc, int frames);
    int m = 0;
    for (int i = 0; i < n_out && i < n_exp; i++)
      if (obits[i] !== ^syms[i]) m++;
    chk({t, " out count"}, n_out, n_exp);
    chk({t, " bit errors"}, m, 0);
    chk({t, " accepts"}, n_acc, exp_acc);
    chk({t, " force accepts"}, n_facc, LAG * frames);
    chk({t, " last count"}, n_last, frames);
    chk({t, " last position"}, last_at[frames - 1], n_exp - 1);
  endtask

  initial begin
    logic [1:0] t1[5];
    vt[0] = '{iv: 0, sym: 2'b00, rdy: 0, e_ir: 0, e_cv: 0, e_cs: 2'b00};
    vt[1] = '{iv: 1, sym: 2'b10, rdy: 0, e_ir: 0, e_cv: 1, e_cs: 2'b10};
    vt[2] = '{iv: 0, sym: 2'b11, rdy: 1, e_ir: 1, e_cv: 0, e_cs: 2'b00};
    vt[3] = '{iv: 1, sym: 2'b01, rdy: 1, e_ir: 1, e_cv: 1, e_cs: 2'b01};
    t1 = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    clear_mon();
    first_wait = 0;
    repeat (3) @(negedge clk);
    #4;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_bit", out_bit, 0);
    chk("reset out_last", out_last, 0);
    chk("reset busy", busy, 0);
    chk("reset len_err", len_err, 0);
    chk("reset force_state0", core_force_state0, 0);
    chk("reset core_sym_valid", core_sym_valid, 0);
    chk("reset in_ready", in_ready, core_sym_ready);
    @(negedge clk);
    #2 rst = 0;

    rdy_mode = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      in_valid = vt[i].iv; in_sym = vt[i].sym; core_sym_ready = vt[i].rdy;
      #1;
      chk($sformatf("idle vec%0d in_ready", i), in_ready, vt[i].e_ir);
      chk($sformatf("idle vec%0d core_valid", i), core_sym_valid, vt[i].e_cv);
      if (vt[i].e_cv) chk($sformatf("idle vec%0d core_sym", i), core_sym, vt[i].e_cs);
      chk($sformatf("idle vec%0d force", i), core_force_state0, 0);
      in_valid = 0;
    end
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    clear_mon();
    for (int i = 0; i < 5; i++) syms[i] = t1[i];
    send(5, 0, 1);
    wait_idle();
    check_out("t1", 5, 5 + LAG, 1);
    chk("t1 busy falls one cycle after last", fall_cyc - last_cyc, 1);

    clear_mon();
    fill(1, 3);
    send(1, 0, 1);
    wait_idle();
    check_out("t2", 1, 1 + LAG, 1);

    clear_mon();
    fill(16, 1);
    send(8, 0, 0);
    send(8, 8, 1);
    wait_idle();
    check_out("t3", 16, 16 + 2 * LAG, 2);
    chk("t3 first last position", last_at[0], 7);
    chk("t3 second frame stalled", first_wait > LAG, 1);

    clear_mon();
    rdy_mode = 1;
    fill(12, 2);
    send(12, 0, 1);
    wait_idle();
    rdy_mode = 0;
    check_out("t4", 12, 12 + LAG, 1);

    clear_mon();
    fill(MAXF + 3, 0);
    send(MAXF + 3, 0, 1);
    wait_idle();
    check_out("t5", MAXF, MAXF + 3 + LAG, 1);
    chk("t5 len_err set", len_err, 1);

    clear_mon();
    fill(2, 1);
    send(2, 0, 1);
    wait_idle();
    check_out("t5b", 2, 2 + LAG, 1);
    chk("t5b len_err sticky", len_err, 1);

    clear_mon();
    fill(5, 2);
    send(5, 0, 1);
    repeat (5) @(negedge clk);
    #4;
    chk("t6 in flush before reset", core_force_state0 && core_sym_valid, 1);
    @(negedge clk);
    #2 rst = 1;
    #2;
    chk("t6 rst out_valid", out_valid, 0);
    chk("t6 rst out_last", out_last, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst len_err", len_err, 0);
    chk("t6 rst force", core_force_state0, 0);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    #4;
    chk("t6 post out_valid", out_valid, 0);
    chk("t6 post busy", busy, 0);
    chk("t6 post last count", n_last, 0);
    clear_mon();
    fill(3, 1);
    send(3, 0, 1);
    wait_idle();
    check_out("t6", 3, 3 + LAG, 1);

    chk("in_ready low in flush/drain", bad_ready, 0);
    chk("force low in idle", bad_force, 0);
    chk("out_last only with out_valid", bad_last, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
